// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs one lw/sw at a time on a req/ack bus,
// stalls the pipeline while it waits and qualifies RegWrite into MEM/WB.
module mem_stage_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic                  MemWriteM,
    input  logic [DATA_WIDTH-1:0] alu_resultM,
    input  logic [DATA_WIDTH-1:0] write_dataM,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] read_dataM,
    output logic                  RegWriteM_q,
    output logic                  stallM,
    output logic                  misalign_err,
    output logic                  bus_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          err;

    logic access;
    logic aligned;
    logic start;

    always_comb begin
        access  = MemtoRegM | MemWriteM;
        aligned = (alu_resultM[1:0] == 2'b00);
        start   = (state == IDLE) & access & aligned;
    end

    // Stall cycles present a bubble to MEM/WB; the write is released in DONE.
    always_comb begin
        stallM       = 1'b0;
        misalign_err = 1'b0;
        RegWriteM_q  = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    stallM       = aligned;
                    misalign_err = ~aligned;
                end else begin
                    RegWriteM_q = RegWriteM;
                end
            end
            WAIT: begin
                stallM = 1'b1;
            end
            DONE: begin
                RegWriteM_q = RegWriteM & ~err;
            end
            default: begin
                stallM = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            err        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            read_dataM <= '0;
            bus_err    <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteM;
                        mem_addr  <= alu_resultM;
                        mem_wdata <= write_dataM;
                        cnt       <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            read_dataM <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        state   <= DONE;
                    end else if (cnt == CNT_MAX) begin
                        mem_req    <= 1'b0;
                        bus_err    <= 1'b1;
                        read_dataM <= '0;
                        err        <= 1'b1;
                        cnt        <= '0;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: each instruction pushes its expected
// MEM/WB result, popped when the stage releases the instruction.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] alu_resultM, write_dataM, mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, read_dataM;
    logic        RegWriteM_q, stallM, misalign_err, bus_err;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        rw;
        logic [31:0] rd;
        logic        mis;
        logic        berr;
        int          stalls;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] rd_model = '0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .alu_resultM(alu_resultM), .write_dataM(write_dataM),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .read_dataM(read_dataM), .RegWriteM_q(RegWriteM_q),
        .stallM(stallM), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
        alu_resultM = 32'h0; write_dataM = 32'h0;
    endtask

    // Called just after a rising edge. ack_wait = WAIT cycle carrying the
    // ack (1-based), 0 = never acknowledge.
    task automatic run_instr(input logic rw, input logic m2r, input logic mw,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int ack_wait);
        exp_t e, got;
        logic acc, al, tmo;
        int stalls, wait_n;
        bit done;
        acc = m2r | mw;
        al  = (addr[1:0] == 2'b00);
        tmo = acc && al && (ack_wait < 1 || ack_wait > 16);
        e.mis    = acc & ~al;
        e.berr   = tmo;
        e.rw     = (acc && (!al || tmo)) ? 1'b0 : rw;
        e.stalls = (!acc || !al) ? 0 : (tmo ? 17 : 1 + ack_wait);
        if (tmo) rd_model = '0;
        else if (acc && al && !mw) rd_model = rdata;
        e.rd = rd_model;
        sbq.push_back(e);

        RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
        alu_resultM = addr; write_dataM = wd; mem_rdata = rdata;
        stalls = 0; wait_n = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!stallM) begin
                got = sbq.pop_front();
                check("regwrite_q", {31'b0, RegWriteM_q}, {31'b0, got.rw});
                check("read_data", read_dataM, got.rd);
                check("misalign", {31'b0, misalign_err}, {31'b0, got.mis});
                check("bus_err", {31'b0, bus_err}, {31'b0, got.berr});
                check("stall_cycles", stalls, got.stalls);
                check("req_released", {31'b0, mem_req}, 32'h0);
                done = 1;
            end else begin
                stalls++;
                if (mem_req) begin
                    wait_n++;
                    check("addr_stable", mem_addr, addr);
                    check("we", {31'b0, mem_we}, {31'b0, mw});
                    if (mw) check("wdata", mem_wdata, wd);
                    if (wait_n == ack_wait) mem_ack = 1'b1;
                end
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        if (!done) check("instr_timeout", 32'h0, 32'h1);
        go_idle();
        @(negedge clk);
        check("idle_req", {31'b0, mem_req}, 32'h0);
        check("idle_berr", {31'b0, bus_err}, 32'h0);
        check("idle_stall", {31'b0, stallM}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1; mem_ack = 0; mem_rdata = '0;
        go_idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_req", {31'b0, mem_req}, 32'h0);
        check("rst_we", {31'b0, mem_we}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_rdata", read_dataM, 32'h0);
        check("rst_berr", {31'b0, bus_err}, 32'h0);
        check("rst_stall", {31'b0, stallM}, 32'h0);
        @(posedge clk); #1;

        run_instr(1, 0, 0, 32'h0000_1234, 32'h0, 32'h0, 0);
        run_instr(1, 1, 0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 2);
        run_instr(0, 0, 1, 32'h0000_0204, 32'h1234_5678, 32'hDEAD_BEEF, 1);
        run_instr(1, 1, 0, 32'h0000_0102, 32'h0, 32'h5555_AAAA, 1);
        run_instr(0, 1, 1, 32'h0000_0300, 32'hA5A5_5A5A, 32'h1111_2222, 3);
        run_instr(1, 1, 0, 32'h0000_0400, 32'h0, 32'h7777_8888, 0);
        run_instr(1, 1, 0, 32'h0000_0500, 32'h0, $urandom, 5);
        run_instr(1, 1, 0, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 16);
        run_instr(0, 0, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);

        // Reset during the third WAIT cycle; the late ack must be ignored.
        RegWriteM = 1; MemtoRegM = 1; alu_resultM = 32'h0000_0700;
        mem_rdata = 32'h3333_4444;
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            @(posedge clk); #1;
            @(negedge clk);
        end
        check("pre_rst_req", {31'b0, mem_req}, 32'h1);
        rst = 1'b1;
        MemtoRegM = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        check("rst_wait_req", {31'b0, mem_req}, 32'h0);
        check("rst_wait_addr", mem_addr, 32'h0);
        check("rst_wait_rd", read_dataM, 32'h0);
        check("rst_wait_stall", {31'b0, stallM}, 32'h0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("ack_ignored_rd", read_dataM, 32'h0);
        check("ack_ignored_req", {31'b0, mem_req}, 32'h0);
        check("ack_ignored_berr", {31'b0, bus_err}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
